// File: rtl/register_alu_datapath.sv
// Register-file + ALU datapath driven by the controller's per-cycle micro-ops.
// R0..R6 are stored, R7 reads a constant, and R6 also has an external load port.
module register_alu_datapath #(
  parameter int DATAWIDTH     = 8,
  parameter int SELECTIONALU  = 3,
  parameter int SELECTIONDECO = 3,
  parameter logic [DATAWIDTH-1:0] R7CONST = 8'h01
) (
  input  logic                     clk,
  input  logic                     lowRst,
  input  logic [SELECTIONDECO-1:0] sSelDecoA,
  input  logic [SELECTIONDECO-1:0] sSelDecoB,
  input  logic [SELECTIONDECO-1:0] sSelDecoC,
  input  logic [SELECTIONALU-1:0]  sSelAlu,
  input  logic                     pLoad,
  input  logic [DATAWIDTH-1:0]     pLoadData,
  output logic [DATAWIDTH-1:0]     pAluOut,
  output logic [DATAWIDTH-1:0]     pR0Out,
  output logic                     sOverflow,
  output logic                     sCarry,
  output logic                     sNegative,
  output logic                     sZero,
  output logic                     sPar
);

  localparam int NSTORED = 7;
  localparam int MSB     = DATAWIDTH - 1;

  logic [DATAWIDTH-1:0] regs_reg [0:NSTORED-1];
  logic [DATAWIDTH-1:0] rd_bank  [0:NSTORED];
  logic [NSTORED-1:0]   wr_en;
  logic [DATAWIDTH-1:0] opa, opb, alu_result;
  logic [DATAWIDTH:0]   sum_ext, diff_ext;
  logic                 carry_next, overflow_next;

  // Per-register write enables and the read bank (R7 is a constant, not storage).
  genvar gi;
  generate
    for (gi = 0; gi < NSTORED; gi++) begin : g_bank
      assign wr_en[gi]   = (sSelDecoC == SELECTIONDECO'(gi));
      assign rd_bank[gi] = regs_reg[gi];
    end
  endgenerate
  assign rd_bank[NSTORED] = R7CONST;

  assign opa    = rd_bank[sSelDecoA];
  assign opb    = rd_bank[sSelDecoB];
  assign pR0Out = regs_reg[0];

  assign sum_ext  = {1'b0, opa} + {1'b0, opb};
  assign diff_ext = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    alu_result    = opa;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    case (sSelAlu)
      3'b000: alu_result = opa;
      3'b001: begin
        alu_result    = sum_ext[MSB:0];
        carry_next    = sum_ext[DATAWIDTH];
        overflow_next = (opa[MSB] == opb[MSB]) && (sum_ext[MSB] != opa[MSB]);
      end
      3'b010: begin
        // Extended-width subtraction leaves the unsigned borrow in the top bit.
        alu_result    = diff_ext[MSB:0];
        carry_next    = diff_ext[DATAWIDTH];
        overflow_next = (opa[MSB] != opb[MSB]) && (diff_ext[MSB] != opa[MSB]);
      end
      3'b011: alu_result = opa & opb;
      3'b100: begin
        alu_result    = {opa[MSB-1:0], 1'b0};
        carry_next    = opa[MSB];
        overflow_next = opa[MSB] != opa[MSB-1];
      end
      3'b101: begin
        alu_result = {1'b0, opa[MSB:1]};
        carry_next = opa[0];
      end
      3'b110: alu_result = opa | opb;
      3'b111: alu_result = opa ^ opb;
      default: alu_result = opa;
    endcase
  end

  assign pAluOut = alu_result;

  // ALU write into R6 takes priority over the external load in the same cycle.
  always_ff @(posedge clk or posedge lowRst) begin
    if (lowRst) begin
      for (int i = 0; i < NSTORED; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NSTORED; i++) begin
        if (wr_en[i])
          regs_reg[i] <= alu_result;
        else if (i == NSTORED - 1 && pLoad)
          regs_reg[i] <= pLoadData;
      end
    end
  end

  // Flags track every cycle's ALU op, regardless of whether it is written back.
  always_ff @(posedge clk or posedge lowRst) begin
    if (lowRst) begin
      sOverflow <= 1'b0;
      sCarry    <= 1'b0;
      sNegative <= 1'b0;
      sZero     <= 1'b0;
      sPar      <= 1'b0;
    end else begin
      sOverflow <= overflow_next;
      sCarry    <= carry_next;
      sNegative <= alu_result[MSB];
      sZero     <= (alu_result == '0);
      sPar      <= ^alu_result;
    end
  end

endmodule
